// File: rtl/fp_operand_loader_pkg.sv
// Shared constants and packing helper for the FP operand loader.
// The FP_LOAD_ROUND_EN macro selects round-to-nearest-even packing.
package fp_operand_loader_pkg;

   localparam int unsigned FP_BIAS  = 127;
   localparam logic [31:0] FP_ZERO  = 32'h0000_0000;
   // A 32-bit magnitude normalised to bit 31 carries exponent 2^31.
   localparam logic [7:0]  EXP_INIT = 8'(FP_BIAS + 31);

   typedef enum logic {
      TGT_A,
      TGT_B
   } target_e;

   function automatic logic [31:0] fp_pack(input logic s, input logic [7:0] e, input logic [22:0] m);
      return {s, e, m};
   endfunction

endpackage

// File: rtl/fp_operand_loader_rne.sv
// Combinational round-to-nearest-even of a normalised magnitude into {exp, mant}.
// Present only when FP_LOAD_ROUND_EN is defined.
`ifdef FP_LOAD_ROUND_EN
module fp_operand_loader_rne (
   input  logic [7:0]  exp_i,
   input  logic [30:0] mag_i,
   output logic [7:0]  exp_o,
   output logic [22:0] mant_o
);

   logic        guard;
   logic        sticky;
   logic        lsb;
   logic        inc;
   logic [30:0] em;

   assign guard  = mag_i[7];
   assign sticky = |mag_i[6:0];
   assign lsb    = mag_i[8];
   assign inc    = guard & (sticky | lsb);

   // Mantissa carry-out ripples straight into the exponent field.
   assign em = {exp_i, mag_i[30:8]} + 31'(inc);

   assign exp_o  = em[30:23];
   assign mant_o = em[22:0];

endmodule
`endif

// File: rtl/fp_operand_loader.sv
// Integer-to-float operand loader and issue sequencer for the FP multiplier.
// Define FP_LOAD_ROUND_EN for RNE packing; otherwise the low 8 magnitude bits are truncated.
module fp_operand_loader
   import fp_operand_loader_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] int_in,
   input  logic        load_a,
   input  logic        load_b,
   input  logic        go,
   input  logic        mul_done,
   output logic [31:0] a,
   output logic [31:0] b,
   output logic        start,
   output logic        a_valid,
   output logic        b_valid,
   output logic        busy,
   output logic        go_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ABS,
      S_NORM,
      S_PACK,
      S_ISSUE,
      S_WAIT
   } state_e;

   state_e      state_q;
   target_e     tgt_q;
   logic [31:0] int_q;
   logic        sign_q;
   logic [31:0] mag_q;
   logic [7:0]  exp_q;
   logic [31:0] cnt_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic        a_valid_q;
   logic        b_valid_q;
   logic        start_q;
   logic        go_err_q;

   logic [7:0]  pack_exp;
   logic [22:0] pack_mant;
   logic [31:0] pack_d;

`ifdef FP_LOAD_ROUND_EN
   fp_operand_loader_rne u_rne (
      .exp_i  (exp_q),
      .mag_i  (mag_q[30:0]),
      .exp_o  (pack_exp),
      .mant_o (pack_mant)
   );
`else
   assign pack_exp  = exp_q;
   assign pack_mant = mag_q[30:8];
`endif

   // A zero magnitude never normalises, so it is forced to +0.0 rather than packed.
   assign pack_d = (mag_q == '0) ? FP_ZERO : fp_pack(sign_q, pack_exp, pack_mant);

   // NOTE: every register here is assigned with <= so all updates see pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         tgt_q     <= TGT_A;
         int_q     <= '0;
         sign_q    <= 1'b0;
         mag_q     <= '0;
         exp_q     <= '0;
         cnt_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         a_valid_q <= 1'b0;
         b_valid_q <= 1'b0;
         start_q   <= 1'b0;
         go_err_q  <= 1'b0;
      end else begin
         start_q  <= 1'b0;
         go_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (load_a || load_b) begin
                  int_q   <= int_in;
                  tgt_q   <= load_a ? TGT_A : TGT_B;
                  state_q <= S_ABS;
                  if (load_a) a_valid_q <= 1'b0;
                  else        b_valid_q <= 1'b0;
               end else if (go) begin
                  if (a_valid_q && b_valid_q) begin
                     start_q <= 1'b1;
                     cnt_q   <= '0;
                     state_q <= S_ISSUE;
                  end else begin
                     go_err_q <= 1'b1;
                  end
               end
            end
            S_ABS: begin
               sign_q  <= int_q[31];
               mag_q   <= int_q[31] ? (~int_q + 32'd1) : int_q;
               exp_q   <= EXP_INIT;
               state_q <= (int_q == '0) ? S_PACK : S_NORM;
            end
            S_NORM: begin
               if (mag_q[31]) begin
                  state_q <= S_PACK;
               end else begin
                  mag_q <= mag_q << 1;
                  exp_q <= exp_q - 8'd1;
               end
            end
            S_PACK: begin
               if (tgt_q == TGT_A) begin
                  a_q       <= pack_d;
                  a_valid_q <= 1'b1;
               end else begin
                  b_q       <= pack_d;
                  b_valid_q <= 1'b1;
               end
               state_q <= S_IDLE;
            end
            S_ISSUE: begin
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (mul_done) begin
                  a_valid_q <= 1'b0;
                  b_valid_q <= 1'b0;
                  state_q   <= S_IDLE;
               end else if (TIMEOUT != 0 && cnt_q == 32'(TIMEOUT - 1)) begin
                  go_err_q <= 1'b1;
                  state_q  <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign a       = a_q;
   assign b       = b_q;
   assign start   = start_q;
   assign a_valid = a_valid_q;
   assign b_valid = b_valid_q;
   assign go_err  = go_err_q;
   assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_operand_loader.sv
// Scoreboard bench for fp_operand_loader: stimulus queues expected events, a monitor checks them.
// Honours FP_LOAD_ROUND_EN in its reference model.
module tb_fp_operand_loader;

   localparam int unsigned TO = 8;
`ifdef FP_LOAD_ROUND_EN
   localparam bit ROUND = 1'b1;
`else
   localparam bit ROUND = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] int_in;
   logic        load_a, load_b, go, mul_done;
   logic [31:0] a, b;
   logic        start, a_valid, b_valid, busy, go_err;

   fp_operand_loader #(.TIMEOUT(TO)) dut (
      .clk      (clk),
      .reset    (reset),
      .int_in   (int_in),
      .load_a   (load_a),
      .load_b   (load_b),
      .go       (go),
      .mul_done (mul_done),
      .a        (a),
      .b        (b),
      .start    (start),
      .a_valid  (a_valid),
      .b_valid  (b_valid),
      .busy     (busy),
      .go_err   (go_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum int {EV_A, EV_B, EV_START, EV_ERR} ev_kind_e;
   typedef struct {
      ev_kind_e    kind;
      int          cyc;
      logic [31:0] val;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   logic [31:0] ma_val = '0, mb_val = '0;
   bit          ma_v = 1'b0, mb_v = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Value from the IEEE-754 rules: locate the leading one, keep 23 fraction bits, optionally RNE.
   function automatic logic [31:0] ref_float(input logic [31:0] v, output int lat);
      longint unsigned m, mant, rem, half;
      int              p, sh;
      logic [31:0]     e;
      m = v[31] ? (64'h1_0000_0000 - {32'h0, v}) : {32'h0, v};
      if (m == 0) begin
         lat = 3;
         return 32'h0;
      end
      p = 0;
      for (int i = 0; i < 32; i++) if (m[i]) p = i;
      lat = 4 + (31 - p);
      e   = 127 + p;
      if (p <= 23) begin
         mant = m << (23 - p);
      end else begin
         sh   = p - 23;
         mant = m >> sh;
         rem  = m & ((64'd1 << sh) - 1);
         half = 64'd1 << (sh - 1);
         if (ROUND && (rem > half || (rem == half && mant[0]))) mant++;
      end
      if (mant == 64'h100_0000) begin
         mant = 64'h80_0000;
         e    = e + 1;
      end
      return {v[31], e[7:0], mant[22:0]};
   endfunction

   // Monitor: each rising valid, start or go_err is matched against the scoreboard head.
   bit  prev_av = 1'b0, prev_bv = 1'b0;
   bit  have;
   ev_t got, want;
   always @(negedge clk) begin
      have = 1'b0;
      if (a_valid && !prev_av)      begin got = '{EV_A, cyc, a};         have = 1'b1; end
      else if (b_valid && !prev_bv) begin got = '{EV_B, cyc, b};         have = 1'b1; end
      else if (start)               begin got = '{EV_START, cyc, 32'h0}; have = 1'b1; end
      else if (go_err)              begin got = '{EV_ERR, cyc, 32'h0};   have = 1'b1; end
      prev_av = a_valid;
      prev_bv = b_valid;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         want = exp_q.pop_front();
         check("event missing", 32'(int'(EV_ERR) + 1), 32'(int'(want.kind)));
      end
      if (have) begin
         if (exp_q.size() == 0) begin
            check("unexpected event", 32'(int'(got.kind)), 32'hFFFF_FFFF);
         end else begin
            want = exp_q.pop_front();
            check("event kind", 32'(int'(got.kind)), 32'(int'(want.kind)));
            check("event cycle", got.cyc, want.cyc);
            check("event value", got.val, want.val);
         end
      end
   end

   task automatic idle_wait();
      int k = 0;
      while (busy && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("idle reached", 32'(busy), 32'h0);
   endtask

   task automatic check_operands(input string tag);
      check({tag, " a"}, a, ma_val);
      check({tag, " b"}, b, mb_val);
      check({tag, " a_valid"}, 32'(a_valid), 32'(ma_v));
      check({tag, " b_valid"}, 32'(b_valid), 32'(mb_v));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " a"}, a, 32'h0);
      check({tag, " b"}, b, 32'h0);
      check({tag, " valids"}, {30'h0, a_valid, b_valid}, 32'h0);
      check({tag, " start"}, 32'(start), 32'h0);
      check({tag, " go_err"}, 32'(go_err), 32'h0);
      check({tag, " busy"}, 32'(busy), 32'h0);
   endtask

   // poke: try a load of the other operand while converting; with_go: go alongside the load.
   task automatic do_load(input bit tgt_b, input logic [31:0] v, input bit poke, input bit with_go);
      int          lat;
      logic [31:0] f;
      f = ref_float(v, lat);
      @(negedge clk);
      int_in = v;
      load_a = !tgt_b;
      load_b = tgt_b;
      go     = with_go;
      exp_q.push_back('{tgt_b ? EV_B : EV_A, cyc + lat, f});
      @(negedge clk);
      load_a = 1'b0;
      load_b = 1'b0;
      go     = 1'b0;
      int_in = $urandom;
      check("valid drop on load", 32'(tgt_b ? b_valid : a_valid), 32'h0);
      check("busy in convert", 32'(busy), 32'h1);
      if (poke) begin
         load_a = tgt_b;
         load_b = !tgt_b;
         @(negedge clk);
         load_a = 1'b0;
         load_b = 1'b0;
      end
      idle_wait();
      if (tgt_b) begin mb_val = f; mb_v = 1'b1; end
      else       begin ma_val = f; ma_v = 1'b1; end
      check_operands("after load");
   endtask

   // dly in 0..TO-1: mul_done in that WAIT cycle; otherwise let it time out.
   task automatic do_go(input int dly);
      int c;
      bit issue;
      @(negedge clk);
      go    = 1'b1;
      c     = cyc;
      issue = ma_v && mb_v;
      if (issue) exp_q.push_back('{EV_START, c + 1, 32'h0});
      else       exp_q.push_back('{EV_ERR, c + 1, 32'h0});
      @(negedge clk);
      go = 1'b0;
      if (!issue) begin
         check("stay idle on rejected go", 32'(busy), 32'h0);
      end else begin
         check("busy in issue", 32'(busy), 32'h1);
         mul_done = 1'($urandom_range(0, 1));
         if (dly >= 0 && dly < int'(TO)) begin
            repeat (dly + 1) begin
               @(negedge clk);
               mul_done = 1'b0;
            end
            mul_done = 1'b1;
            @(negedge clk);
            mul_done = 1'b0;
            ma_v = 1'b0;
            mb_v = 1'b0;
         end else begin
            exp_q.push_back('{EV_ERR, c + int'(TO) + 2, 32'h0});
            repeat (TO + 1) begin
               @(negedge clk);
               mul_done = 1'b0;
            end
         end
         check("idle after wait", 32'(busy), 32'h0);
      end
      check_operands("after go");
   endtask

   task automatic do_spurious_done();
      @(negedge clk);
      mul_done = 1'b1;
      @(negedge clk);
      mul_done = 1'b0;
      check_operands("done outside wait");
   endtask

   function automatic logic [31:0] rand_int();
      logic [31:0] v;
      case ($urandom_range(0, 3))
         0:       v = $urandom;
         1:       v = $urandom >> $urandom_range(0, 31);
         2:       v = -($urandom >> $urandom_range(0, 31));
         default: v = 32'(1) << $urandom_range(0, 31);
      endcase
      return v;
   endfunction

   initial begin
      reset = 1'b1; int_in = '0; load_a = 1'b0; load_b = 1'b0; go = 1'b0; mul_done = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;

      do_go(0);
      do_load(1'b0, 32'd1, 1'b0, 1'b0);
      do_go(0);
      do_load(1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0);
      do_load(1'b1, 32'h0, 1'b0, 1'b0);
      do_go(4);
      do_load(1'b0, 32'h8000_0000, 1'b0, 1'b0);
      do_load(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0);
      do_go(-1);
      do_go(TO - 1);
      do_load(1'b0, 32'd16777219, 1'b1, 1'b0);
      do_load(1'b1, 32'd6, 1'b0, 1'b1);
      do_spurious_done();
      do_go(0);

      // Reset mid-normalisation aborts the conversion and clears everything.
      @(negedge clk);
      int_in = 32'd1;
      load_a = 1'b1;
      @(negedge clk);
      load_a = 1'b0;
      repeat (5) @(negedge clk);
      check("busy before reset", 32'(busy), 32'h1);
      reset = 1'b1;
      @(negedge clk);
      check_all_zero("mid-norm reset");
      reset  = 1'b0;
      ma_val = '0; mb_val = '0; ma_v = 1'b0; mb_v = 1'b0;

      // Simultaneous loads: A has priority, B untouched.
      begin
         int          lat;
         logic [31:0] f;
         f = ref_float(32'd5, lat);
         @(negedge clk);
         int_in = 32'd5;
         load_a = 1'b1;
         load_b = 1'b1;
         exp_q.push_back('{EV_A, cyc + lat, f});
         @(negedge clk);
         load_a = 1'b0;
         load_b = 1'b0;
         idle_wait();
         ma_val = f;
         ma_v   = 1'b1;
         check_operands("dual load");
      end

      for (int i = 0; i < 40; i++) begin
         int r, d;
         r = $urandom_range(0, 9);
         if (r <= 3)      do_load(1'b0, rand_int(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         else if (r <= 6) do_load(1'b1, rand_int(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         else if (r <= 8) begin
            d = $urandom_range(0, TO);
            do_go(d == int'(TO) ? -1 : d);
         end else         do_spurious_done();
      end

      repeat (4) @(negedge clk);
      check("scoreboard drained", exp_q.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
